// File: rtl/idec_pkg.sv
// idec_pkg: shared definitions for the RV32I decode stage.
//   XLEN           datapath width (only 32 supported)
//   OP_*           base opcode values, inst[6:0]
//   opclass_e      4-bit operation class handed to execute
//   imm_fmt_e      immediate format selected by field decode
package idec_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    OPC_ALU_R   = 4'd0,
    OPC_ALU_I   = 4'd1,
    OPC_LOAD    = 4'd2,
    OPC_STORE   = 4'd3,
    OPC_BRANCH  = 4'd4,
    OPC_JAL     = 4'd5,
    OPC_JALR    = 4'd6,
    OPC_LUI     = 4'd7,
    OPC_AUIPC   = 4'd8,
    OPC_FENCE   = 4'd9,
    OPC_SYSTEM  = 4'd10,
    OPC_MULDIV  = 4'd11,
    OPC_ILLEGAL = 4'd15
  } opclass_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/idec_if.sv
// idec_if: upstream/downstream handshake and decoded payload of the decode stage.
//   master : the surrounding pipeline (drives valid_i/pc_i/inst_i/flush_i/ready_i)
//   slave  : idec (drives ready_o and all *_ro outputs)
interface idec_if;
  import idec_pkg::*;

  logic             valid_i;
  logic             ready_o;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  inst_i;
  logic             flush_i;
  logic             valid_ro;
  logic             ready_i;
  logic [XLEN-1:0]  pc_ro;
  logic [XLEN-1:0]  inst_ro;
  logic [4:0]       rd_ro;
  logic [4:0]       rs1_ro;
  logic [4:0]       rs2_ro;
  logic             rs1_used_ro;
  logic             rs2_used_ro;
  logic [2:0]       funct3_ro;
  logic             alt_ro;
  logic [3:0]       opclass_ro;
  logic [XLEN-1:0]  imm_ro;
  logic             illegal_ro;

  modport master (
    output valid_i, pc_i, inst_i, flush_i, ready_i,
    input  ready_o, valid_ro, pc_ro, inst_ro, rd_ro, rs1_ro, rs2_ro,
           rs1_used_ro, rs2_used_ro, funct3_ro, alt_ro, opclass_ro, imm_ro, illegal_ro
  );

  modport slave (
    input  valid_i, pc_i, inst_i, flush_i, ready_i,
    output ready_o, valid_ro, pc_ro, inst_ro, rd_ro, rs1_ro, rs2_ro,
           rs1_used_ro, rs2_used_ro, funct3_ro, alt_ro, opclass_ro, imm_ro, illegal_ro
  );

endinterface

// File: rtl/idec_immgen.sv
// idec_immgen: combinational RV32I immediate generator.
//   inst  in  inst[31:7] (opcode bits never contribute to an immediate)
//   fmt   in  immediate format
//   imm   out sign-extended immediate, 0 for IMM_NONE
module idec_immgen
  import idec_pkg::*;
(
  input  logic [31:7] inst,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/idec.sv
// idec: RV32I decode stage with a valid/ready pipeline register.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          idec_if.slave: {valid_i, pc_i, inst_i} in, ready_o back,
//                flush_i redirect kill, decoded fields *_ro out, ready_i from execute
// Optional macro IDEC_RV32M_EN: decode funct7=0000001 on OP as OPC_MULDIV
// (illegal when undefined).
module idec
  import idec_pkg::*;
#(
  parameter int XLEN = idec_pkg::XLEN
) (
  input  logic  clk,
  input  logic  rst_n,
  idec_if.slave bus
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  opclass_e    opc_d;
  imm_fmt_e    fmt_d;
  logic        rd_wr, rs1_use, rs2_use, alt_d, ill_d;
  logic [31:0] imm_d;

  assign opcode = bus.inst_i[6:0];
  assign funct3 = bus.inst_i[14:12];
  assign funct7 = bus.inst_i[31:25];

  always_comb begin
    opc_d   = OPC_ILLEGAL;
    fmt_d   = IMM_NONE;
    rd_wr   = 1'b0;
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    alt_d   = 1'b0;
    ill_d   = 1'b0;
    case (opcode)
      OP_OP: begin
        opc_d   = OPC_ALU_R;
        rd_wr   = 1'b1;
        rs1_use = 1'b1;
        rs2_use = 1'b1;
        alt_d   = bus.inst_i[30];
        if (funct7 == 7'b0100000) begin
          ill_d = !(funct3 == 3'b000 || funct3 == 3'b101);
        end else if (funct7 == 7'b0000001) begin
`ifdef IDEC_RV32M_EN
          opc_d = OPC_MULDIV;
`else
          ill_d = 1'b1;
`endif
        end else if (funct7 != 7'b0000000) begin
          ill_d = 1'b1;
        end
      end
      OP_IMM: begin
        opc_d   = OPC_ALU_I;
        fmt_d   = IMM_I;
        rd_wr   = 1'b1;
        rs1_use = 1'b1;
        if (funct3 == 3'b001) ill_d = (funct7 != 7'b0000000);
        if (funct3 == 3'b101) begin
          ill_d = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          alt_d = bus.inst_i[30];
        end
      end
      OP_LOAD: begin
        opc_d   = OPC_LOAD;
        fmt_d   = IMM_I;
        rd_wr   = 1'b1;
        rs1_use = 1'b1;
        ill_d   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        opc_d   = OPC_STORE;
        fmt_d   = IMM_S;
        rs1_use = 1'b1;
        rs2_use = 1'b1;
        ill_d   = (funct3 > 3'b010);
      end
      OP_BRANCH: begin
        opc_d   = OPC_BRANCH;
        fmt_d   = IMM_B;
        rs1_use = 1'b1;
        rs2_use = 1'b1;
        ill_d   = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        opc_d = OPC_JAL;
        fmt_d = IMM_J;
        rd_wr = 1'b1;
      end
      OP_JALR: begin
        opc_d   = OPC_JALR;
        fmt_d   = IMM_I;
        rd_wr   = 1'b1;
        rs1_use = 1'b1;
        ill_d   = (funct3 != 3'b000);
      end
      OP_LUI: begin
        opc_d = OPC_LUI;
        fmt_d = IMM_U;
        rd_wr = 1'b1;
      end
      OP_AUIPC: begin
        opc_d = OPC_AUIPC;
        fmt_d = IMM_U;
        rd_wr = 1'b1;
      end
      OP_FENCE: begin
        opc_d = OPC_FENCE;
        fmt_d = IMM_I;
      end
      OP_SYSTEM: begin
        // ECALL/EBREAK (funct3=000) write nothing; CSR ops write rd and
        // read rs1 only in their register forms (funct3[2]=0).
        opc_d   = OPC_SYSTEM;
        fmt_d   = IMM_I;
        rd_wr   = (funct3 != 3'b000);
        rs1_use = (funct3 != 3'b000) && !funct3[2];
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      opc_d   = OPC_ILLEGAL;
      fmt_d   = IMM_NONE;
      rd_wr   = 1'b0;
      rs1_use = 1'b0;
      rs2_use = 1'b0;
      alt_d   = 1'b0;
    end
  end

  idec_immgen u_immgen (
    .inst (bus.inst_i[31:7]),
    .fmt  (fmt_d),
    .imm  (imm_d)
  );

  logic            valid_q, rs1u_q, rs2u_q, alt_q, ill_q;
  logic [XLEN-1:0] pc_q, inst_q, imm_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      f3_q;
  opclass_e        opc_q;
  logic            cke;

  assign cke = !valid_q || bus.ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs1u_q  <= 1'b0;
      rs2u_q  <= 1'b0;
      f3_q    <= '0;
      alt_q   <= 1'b0;
      opc_q   <= OPC_ILLEGAL;
      imm_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      // Flush drops valid even while stalled; payload is left as-is.
      if (bus.flush_i)  valid_q <= 1'b0;
      else if (cke)     valid_q <= bus.valid_i;
      if (cke && !bus.flush_i) begin
        pc_q   <= bus.pc_i;
        inst_q <= bus.inst_i;
        rd_q   <= rd_wr   ? bus.inst_i[11:7]  : 5'd0;
        rs1_q  <= rs1_use ? bus.inst_i[19:15] : 5'd0;
        rs2_q  <= rs2_use ? bus.inst_i[24:20] : 5'd0;
        rs1u_q <= rs1_use;
        rs2u_q <= rs2_use;
        f3_q   <= funct3;
        alt_q  <= alt_d;
        opc_q  <= opc_d;
        imm_q  <= imm_d;
        ill_q  <= ill_d;
      end
    end
  end

  assign bus.ready_o     = cke;
  assign bus.valid_ro    = valid_q;
  assign bus.pc_ro       = pc_q;
  assign bus.inst_ro     = inst_q;
  assign bus.rd_ro       = rd_q;
  assign bus.rs1_ro      = rs1_q;
  assign bus.rs2_ro      = rs2_q;
  assign bus.rs1_used_ro = rs1u_q;
  assign bus.rs2_used_ro = rs2u_q;
  assign bus.funct3_ro   = f3_q;
  assign bus.alt_ro      = alt_q;
  assign bus.opclass_ro  = opc_q;
  assign bus.imm_ro      = imm_q;
  assign bus.illegal_ro  = ill_q;

endmodule

// File: tb/tb_idec.sv
// tb_idec: directed and randomized bench for idec against a behavioural
// decode model and a one-entry pipeline-register model.
module tb_idec;
  import idec_pkg::*;

`ifdef IDEC_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1u;
    logic        rs2u;
    logic [2:0]  f3;
    logic        alt;
    logic [3:0]  opc;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  idec_if bus_if();

  idec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        exp_valid;
  logic [31:0] exp_pc, exp_inst;
  dec_t        exp_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    bit wr, u1, u2, bad;
    string kind;
    f3 = w[14:12];
    f7 = w[31:25];
    d = '0;
    d.f3 = f3;
    wr = 0; u1 = 0; u2 = 0; bad = 0; kind = "";
    case (w[6:0])
      7'b0110011: begin
        d.opc = 4'd0; wr = 1; u1 = 1; u2 = 1;
        if (f7 == 7'b0000001) begin
          if (M_EN) d.opc = 4'd11; else bad = 1;
        end else if (f7 == 7'b0100000) begin
          bad = !(f3 inside {3'b000, 3'b101});
          d.alt = 1'b1;
        end else bad = (f7 != 7'b0000000);
      end
      7'b0010011: begin
        d.opc = 4'd1; wr = 1; u1 = 1; kind = "I";
        if (f3 == 3'b001) bad = (f7 != 7'b0000000);
        if (f3 == 3'b101) begin
          bad = !(f7 inside {7'b0000000, 7'b0100000});
          d.alt = w[30];
        end
      end
      7'b0000011: begin d.opc = 4'd2; wr = 1; u1 = 1; kind = "I"; bad = f3 inside {3'd3, 3'd6, 3'd7}; end
      7'b0100011: begin d.opc = 4'd3; u1 = 1; u2 = 1; kind = "S"; bad = (f3 > 3'd2); end
      7'b1100011: begin d.opc = 4'd4; u1 = 1; u2 = 1; kind = "B"; bad = f3 inside {3'd2, 3'd3}; end
      7'b1101111: begin d.opc = 4'd5; wr = 1; kind = "J"; end
      7'b1100111: begin d.opc = 4'd6; wr = 1; u1 = 1; kind = "I"; bad = (f3 != 3'd0); end
      7'b0110111: begin d.opc = 4'd7; wr = 1; kind = "U"; end
      7'b0010111: begin d.opc = 4'd8; wr = 1; kind = "U"; end
      7'b0001111: begin d.opc = 4'd9; kind = "I"; end
      7'b1110011: begin
        d.opc = 4'd10; kind = "I";
        wr = (f3 != 3'd0);
        u1 = f3 inside {3'd1, 3'd2, 3'd3};
      end
      default: bad = 1;
    endcase
    if (bad) begin
      d.opc = 4'd15; d.ill = 1'b1; d.alt = 1'b0;
      wr = 0; u1 = 0; u2 = 0; kind = "";
    end
    d.rd   = wr ? w[11:7]  : 5'd0;
    d.rs1  = u1 ? w[19:15] : 5'd0;
    d.rs2  = u2 ? w[24:20] : 5'd0;
    d.rs1u = u1;
    d.rs2u = u2;
    case (kind)
      "I": d.imm = 32'($signed(w[31:20]));
      "S": d.imm = 32'($signed({w[31:25], w[11:7]}));
      "B": d.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      "U": d.imm = {w[31:12], 12'h000};
      "J": d.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: d.imm = 32'h0;
    endcase
    return d;
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_pc    = '0;
    exp_inst  = '0;
    exp_d     = '0;
    exp_d.opc = 4'd15;
  endtask

  task automatic check_outputs();
    chk("valid_ro",    bus_if.valid_ro,    exp_valid);
    chk("pc_ro",       bus_if.pc_ro,       exp_pc);
    chk("inst_ro",     bus_if.inst_ro,     exp_inst);
    chk("rd_ro",       bus_if.rd_ro,       exp_d.rd);
    chk("rs1_ro",      bus_if.rs1_ro,      exp_d.rs1);
    chk("rs2_ro",      bus_if.rs2_ro,      exp_d.rs2);
    chk("rs1_used_ro", bus_if.rs1_used_ro, exp_d.rs1u);
    chk("rs2_used_ro", bus_if.rs2_used_ro, exp_d.rs2u);
    chk("funct3_ro",   bus_if.funct3_ro,   exp_d.f3);
    chk("alt_ro",      bus_if.alt_ro,      exp_d.alt);
    chk("opclass_ro",  bus_if.opclass_ro,  exp_d.opc);
    chk("imm_ro",      bus_if.imm_ro,      exp_d.imm);
    chk("illegal_ro",  bus_if.illegal_ro,  exp_d.ill);
  endtask

  // One clock: drive on the falling edge, check ready_o, advance the
  // model on the rising edge, check registered outputs just after it.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] w,
                      input logic rdy, input logic fl);
    logic cke;
    @(negedge clk);
    bus_if.valid_i = v;
    bus_if.pc_i    = pc;
    bus_if.inst_i  = w;
    bus_if.ready_i = rdy;
    bus_if.flush_i = fl;
    #1;
    chk("ready_o", bus_if.ready_o, !exp_valid || rdy);
    @(posedge clk);
    if (rst_n) begin
      cke = !exp_valid || rdy;
      if (cke && !fl) begin
        exp_pc   = pc;
        exp_inst = w;
        exp_d    = ref_decode(w);
      end
      if (fl)       exp_valid = 1'b0;
      else if (cke) exp_valid = v;
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                             7'b0010111, 7'b0001111, 7'b1110011};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 10)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'b0000000;
      1: w[31:25] = 7'b0100000;
      2: w[31:25] = 7'b0000001;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    bus_if.valid_i = 1'b0;
    bus_if.pc_i    = '0;
    bus_if.inst_i  = '0;
    bus_if.ready_i = 1'b1;
    bus_if.flush_i = 1'b0;
    model_reset();
    #12;
    chk("rst_ready_o", bus_if.ready_o, 32'd1);
    chk("rst_opclass", bus_if.opclass_ro, 32'd15);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,5
    step(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0);
    chk("addi_valid", bus_if.valid_ro, 32'd1);
    chk("addi_opc",   bus_if.opclass_ro, 32'd1);
    chk("addi_rd",    bus_if.rd_ro, 32'd1);
    chk("addi_rs1",   bus_if.rs1_ro, 32'd0);
    chk("addi_rs2u",  bus_if.rs2_used_ro, 32'd0);
    chk("addi_imm",   bus_if.imm_ro, 32'd5);
    // sw x2,-4(x1)
    step(1'b1, 32'h104, 32'hFE20AE23, 1'b1, 1'b0);
    chk("sw_opc", bus_if.opclass_ro, 32'd3);
    chk("sw_rd",  bus_if.rd_ro, 32'd0);
    chk("sw_rs1", bus_if.rs1_ro, 32'd1);
    chk("sw_rs2", bus_if.rs2_ro, 32'd2);
    chk("sw_imm", bus_if.imm_ro, 32'hFFFFFFFC);
    // lui x5,0x12345
    step(1'b1, 32'h108, 32'h123452B7, 1'b1, 1'b0);
    chk("lui_opc", bus_if.opclass_ro, 32'd7);
    chk("lui_rd",  bus_if.rd_ro, 32'd5);
    chk("lui_imm", bus_if.imm_ro, 32'h12345000);
    // all-zero word
    step(1'b1, 32'h10C, 32'h00000000, 1'b1, 1'b0);
    chk("zero_ill", bus_if.illegal_ro, 32'd1);
    chk("zero_opc", bus_if.opclass_ro, 32'd15);
    // mul x3,x1,x2
    step(1'b1, 32'h110, 32'h022081B3, 1'b1, 1'b0);
    chk("mul_opc", bus_if.opclass_ro, M_EN ? 32'd11 : 32'd15);
    chk("mul_ill", bus_if.illegal_ro, M_EN ? 32'd0 : 32'd1);

    // back-pressure: hold addi for three stalled cycles
    step(1'b1, 32'h200, 32'h00500093, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h204 + 32'(i), 32'h123452B7, 1'b0, 1'b0);
      chk("stall_ready_o", bus_if.ready_o, 32'd0);
      chk("stall_valid",   bus_if.valid_ro, 32'd1);
      chk("stall_inst",    bus_if.inst_ro, 32'h00500093);
      chk("stall_pc",      bus_if.pc_ro, 32'h200);
    end

    // flush beats incoming valid; payload holds; next one accepted
    step(1'b1, 32'h300, 32'h123452B7, 1'b1, 1'b1);
    chk("flush_valid", bus_if.valid_ro, 32'd0);
    chk("flush_hold",  bus_if.inst_ro, 32'h00500093);
    step(1'b1, 32'h304, 32'hFE20AE23, 1'b1, 1'b0);
    chk("post_flush_valid", bus_if.valid_ro, 32'd1);
    chk("post_flush_inst",  bus_if.inst_ro, 32'hFE20AE23);
    // flush while stalled
    step(1'b1, 32'h308, 32'h123452B7, 1'b0, 1'b1);
    chk("stall_flush_valid", bus_if.valid_ro, 32'd0);

    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 32'($urandom), rand_inst(),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // asynchronous reset mid-stream
    step(1'b1, 32'h400, 32'h00500093, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid",   bus_if.valid_ro, 32'd0);
    chk("arst_opclass", bus_if.opclass_ro, 32'd15);
    chk("arst_ready_o", bus_if.ready_o, 32'd1);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h500, 32'hFE20AE23, 1'b1, 1'b0);
    step(1'b1, 32'h504, 32'h022081B3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idec.md
Name: idec

Overview:
- RV32I decode stage, directly downstream of the instruction-memory stage; consumes its {valid, pc, inst} and feeds execute.
- Uses the same valid/ready pipeline-register handshake as the upstream stage.
- Registers the PC, the raw instruction and fully decoded fields (register indices, immediate, operation class, illegal flag) with 1-cycle latency.
- Supports a synchronous flush for branch/jump redirect.

Parameters:
- XLEN, 32, datapath width of pc/inst/imm (only 32 supported).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- pc_i  in  32  instruction PC
- inst_i  in  32  raw instruction word
- flush_i  in  1  kill held and incoming instruction
- valid_ro  out  1  downstream valid (registered)
- ready_i  in  1  downstream ready
- pc_ro  out  32  registered PC
- inst_ro  out  32  registered raw instruction
- rd_ro, rs1_ro, rs2_ro  out  5 each  register indices (forced 0 when unused)
- rs1_used_ro, rs2_used_ro  out  1 each  operand-read flags for hazard logic
- funct3_ro  out  3  inst[14:12]
- alt_ro  out  1  inst[30] for R-type/SRAI only, else 0
- opclass_ro  out  4  operation class, encoding from the package
- imm_ro  out  32  sign-extended immediate
- illegal_ro  out  1  illegal instruction

Behaviour:
- Reset is asynchronous, on rst_n low.
  - valid_ro=0, illegal_ro=0, opclass_ro=OPC_ILLEGAL.
  - All other registered outputs are 0.
  - Leaving reset needs no sequencing.
- cke = ~valid_ro | ready_i; ready_o = cke (combinational, no dependence on valid_i).
- On a clk edge with cke=1 and flush_i=0: valid_ro<=valid_i; every payload register loads its decoded value.
- When valid_i=0, payload registers still load (don't-care), but valid_ro is 0.
- cke=0: all registers hold. Outputs stay stable while valid_ro=1 and ready_i=0.
- flush_i=1: valid_ro<=0 on the next edge, regardless of cke, valid_i or ready_i. Flush beats a simultaneous valid_i; payload holds.
- Latency is 1 cycle. Throughput is 1 instruction per cycle when ready_i=1 continuously.
- Opclass is selected by opcode:
  - 0110011 R
  - 0010011 I
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1101111 JAL
  - 1100111 JALR
  - 0110111 LUI
  - 0010111 AUIPC
  - 0001111 FENCE
  - 1110011 SYSTEM
- Immediates, sign-extended from bit 31:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R-type: imm=0.
- Illegal when any of:
  - inst[1:0]!=11, or unknown opcode
  - R-type funct7 not 0000000, or 0100000 with funct3 other than 000/101
  - SLLI funct7!=0, or SRLI/SRAI funct7 not in {0000000, 0100000}
  - LOAD funct3 in {011, 110, 111}
  - STORE funct3 > 010
  - BRANCH funct3 in {010, 011}
  - JALR funct3!=000
- When illegal: opclass=OPC_ILLEGAL, rs1_used=rs2_used=0, rd=0.
- rd is forced to 0 for STORE, BRANCH, FENCE and ECALL/EBREAK, so writeback needs no extra gating.
- x0 destinations are passed through unchanged (rd=0).

Optional Feature:
- Macro IDEC_RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes as OPC_MULDIV, funct3 passed through, rs1/rs2 used.
- Undefined: that encoding is illegal.

Decomposition:
- Package idec_pkg holds:
  - opcode localparams
  - 4-bit opclass encoding: OPC_ALU_R=0, OPC_ALU_I=1, OPC_LOAD=2, OPC_STORE=3, OPC_BRANCH=4, OPC_JAL=5, OPC_JALR=6, OPC_LUI=7, OPC_AUIPC=8, OPC_FENCE=9, OPC_SYSTEM=10, OPC_MULDIV=11, OPC_ILLEGAL=15
  - immediate-format enumeration
- One combinational sub-module, idec_immgen: inst and format in, imm out.
- Field decode and pipeline register stay in idec.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> valid_ro=0, opclass_ro=15 and ready_o=1 asynchronously.
- 0x00500093 (addi x1,x0,5) with valid_i=1, ready_i=1 -> next cycle:
  - valid_ro=1, opclass=1, rd=1, rs1=0, rs2_used=0, imm=5.
- 0xFE20AE23 (sw x2,-4(x1)) -> opclass=3, rd=0, rs1=1, rs2=2, imm=0xFFFFFFFC.
- 0x123452B7 (lui x5) -> opclass=7, rd=5, imm=0x12345000.
- 0x00000000 -> illegal_ro=1, opclass=15.
- 0x022081B3 (mul) -> opclass=11 with IDEC_RV32M_EN defined; illegal_ro=1 without it.
- Back-pressure: ready_i=0 for 3 cycles with valid_ro=1 -> ready_o=0 and outputs stable.
- Flush/accept ordering:
  - flush_i=1 with valid_i=1 -> valid_ro=0 next cycle.
  - A subsequent instruction is then accepted normally.
